bp_be_stride_prefetcher: RTL and testbench

BP_BE_STRIDE_PREFETCHER -- requirements
Module: bp_be_stride_prefetcher

---
 rtl/bp_be_pkg.sv | 30 +++
 rtl/bp_be_stride_pf_arbiter.sv | 24 ++
 rtl/bp_be_stride_prefetcher.sv | 146 ++++++++++++++
 tb/tb_bp_be_stride_prefetcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared back-end types for the stride prefetcher: processor config, stream
// table entry and output FSM encoding.
package bp_be_pkg;

    typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

    localparam int page_offset_width_gp = 12;
    localparam int vaddr_width_gp       = 39;
    localparam int stream_rem_width_gp  = 8;

    // stride is held already sign-extended to full vaddr width
    typedef struct packed {
        logic                                           v;
        logic [vaddr_width_gp-1:0]                      pc;
        logic [vaddr_width_gp-page_offset_width_gp-1:0] page;
        logic [vaddr_width_gp-1:0]                      next_addr;
        logic [vaddr_width_gp-1:0]                      stride;
        logic [stream_rem_width_gp-1:0]                 remaining;
    } bp_stream_entry_s;

    typedef enum logic {e_pf_idle, e_pf_issue} bp_pf_state_e;

    function automatic int vaddr_width_of(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_pf_arbiter.sv
// Round-robin picker: grants the first requesting index after last_i,
// wrapping, with last_i itself considered last.
module bp_be_stride_pf_arbiter
 #(parameter int streams_p = 4
  , localparam int idx_w_lp = (streams_p > 1) ? $clog2(streams_p) : 1)
  (input  logic [streams_p-1:0] req_i
  , input  logic [idx_w_lp-1:0] last_i
  , output logic                v_o
  , output logic [idx_w_lp-1:0] idx_o
  );

    always_comb begin
        v_o   = 1'b0;
        idx_o = '0;
        // walk farthest-first so the nearest requester after last_i wins
        for (int k = streams_p; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % streams_p]) begin
                v_o   = 1'b1;
                idx_o = idx_w_lp'((int'(last_i) + k) % streams_p);
            end
        end
    end

endmodule

// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetcher: stream table fed by stride-detector events, issuing up to
// degree_p same-page prefetches per confirmed stream through a valid/ready port.
module bp_be_stride_prefetcher
    import bp_be_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , parameter int stride_width_p = 8
  , parameter int streams_p      = 4
  , parameter int degree_p       = 2
  , localparam int vaddr_width_p = vaddr_width_of(bp_params_p)
  , localparam int idx_w_lp      = (streams_p > 1) ? $clog2(streams_p) : 1)
  (input  logic                      clk_i
  , input  logic                      reset_n_i
  , input  logic                      start_discovery_i
  , input  logic                      confirm_discovery_i
  , input  logic [vaddr_width_p-1:0]  striding_pc_i
  , input  logic [vaddr_width_p-1:0]  eff_addr_i
  , input  logic [stride_width_p-1:0] stride_i
  , input  logic                      flush_i
  , output logic                      pf_v_o
  , output logic [vaddr_width_p-1:0]  pf_addr_o
  , input  logic                      pf_ready_i
  );

    bp_stream_entry_s tbl_r [streams_p];
    bp_pf_state_e     state_r, state_n;

    logic [vaddr_width_p-1:0] pf_addr_r;
    logic [idx_w_lp-1:0]      victim_r, last_r, cur_idx_r;
    logic                     cur_live_r;

    logic [vaddr_width_p-1:0] stride_sext;
    logic                     conf_en, start_en, hs, load;
    logic                     hit_v, free_v, g_v;
    logic [idx_w_lp-1:0]      hit_idx, free_idx, alloc_idx, g_idx;
    bp_stream_entry_s         new_entry;

    logic [vaddr_width_p-1:0]       eff_next [streams_p];
    logic [stream_rem_width_gp-1:0] eff_rem  [streams_p];
    logic [streams_p-1:0]           adv, same_page, cand;

    assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign conf_en     = confirm_discovery_i & (|stride_i);
    assign start_en    = start_discovery_i & ~confirm_discovery_i & (|stride_i) & hit_v;
    assign pf_v_o      = (state_r == e_pf_issue);
    assign pf_addr_o   = pf_addr_r;
    assign hs          = pf_v_o & pf_ready_i;

    always_comb begin
        hit_v = 1'b0; hit_idx = '0; free_v = 1'b0; free_idx = '0;
        for (int i = streams_p-1; i >= 0; i--) begin
            if (tbl_r[i].v && (tbl_r[i].pc == striding_pc_i)) begin
                hit_v = 1'b1; hit_idx = idx_w_lp'(i);
            end
            if (!tbl_r[i].v) begin
                free_v = 1'b1; free_idx = idx_w_lp'(i);
            end
        end
        alloc_idx = hit_v ? hit_idx : (free_v ? free_idx : victim_r);
    end

    always_comb begin
        new_entry           = '0;
        new_entry.v         = 1'b1;
        new_entry.pc        = striding_pc_i;
        new_entry.page      = eff_addr_i[vaddr_width_p-1:page_offset_width_gp];
        new_entry.next_addr = eff_addr_i + stride_sext;
        new_entry.stride    = stride_sext;
        new_entry.remaining = stream_rem_width_gp'(degree_p);
    end

    // Arbitrate on the post-handshake view so the stream just accepted can
    // be re-granted its following address back-to-back.
    always_comb begin
        for (int i = 0; i < streams_p; i++) begin
            adv[i]       = hs && cur_live_r && (cur_idx_r == idx_w_lp'(i)) && (tbl_r[i].remaining != '0);
            eff_next[i]  = adv[i] ? tbl_r[i].next_addr + tbl_r[i].stride : tbl_r[i].next_addr;
            eff_rem[i]   = adv[i] ? tbl_r[i].remaining - 1'b1 : tbl_r[i].remaining;
            same_page[i] = (eff_next[i][vaddr_width_p-1:page_offset_width_gp] == tbl_r[i].page);
            cand[i]      = tbl_r[i].v && (eff_rem[i] != '0) && same_page[i];
        end
    end

    bp_be_stride_pf_arbiter #(.streams_p(streams_p)) arb
      (.req_i (cand)
      ,.last_i(last_r)
      ,.v_o   (g_v)
      ,.idx_o (g_idx)
      );

    always_comb begin
        state_n = state_r;
        load    = 1'b0;
        case (state_r)
            e_pf_idle:  if (g_v) begin state_n = e_pf_issue; load = 1'b1; end
            e_pf_issue: if (hs) begin
                            if (g_v) load = 1'b1;
                            else     state_n = e_pf_idle;
                        end
            default:    state_n = e_pf_idle;
        endcase
        if (flush_i) begin
            state_n = e_pf_idle;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < streams_p; i++) tbl_r[i] <= '0;
            victim_r <= '0;
        end else begin
            for (int i = 0; i < streams_p; i++) begin
                tbl_r[i].next_addr <= eff_next[i];
                tbl_r[i].remaining <= same_page[i] ? eff_rem[i] : '0;
                if (conf_en && (alloc_idx == idx_w_lp'(i))) tbl_r[i] <= new_entry;
                if (start_en && (hit_idx == idx_w_lp'(i)))  tbl_r[i].v <= 1'b0;
                if (flush_i)                                tbl_r[i].v <= 1'b0;
            end
            if (conf_en && !hit_v && !free_v)
                victim_r <= (victim_r == idx_w_lp'(streams_p-1)) ? '0 : victim_r + 1'b1;
        end
    end

    // cur_live_r drops when a confirm rewrites the in-flight entry, so its
    // eventual handshake no longer advances the fresh stream.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_pf_idle;
            pf_addr_r  <= '0;
            last_r     <= '0;
            cur_idx_r  <= '0;
            cur_live_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (load) begin
                pf_addr_r  <= eff_next[g_idx];
                last_r     <= g_idx;
                cur_idx_r  <= g_idx;
                cur_live_r <= !(conf_en && (alloc_idx == g_idx));
            end else if (conf_en && (alloc_idx == cur_idx_r)) begin
                cur_live_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetcher.sv
// Directed bench with a prefetch-address scoreboard checked on every handshake.
module tb_bp_be_stride_prefetcher;
    import bp_be_pkg::*;

    localparam int VA = 39;

    logic          clk, reset_n, start_d, confirm_d, flush, pf_ready, pf_v;
    logic [VA-1:0] pc, eff, pf_addr;
    logic [7:0]    stride;
    int            checks = 0;
    int            errors = 0;
    logic [VA-1:0] exp_q [$];

    bp_be_stride_prefetcher #(.bp_params_p(e_bp_default_cfg), .stride_width_p(8),
                              .streams_p(4), .degree_p(2)) dut
      (.clk_i(clk), .reset_n_i(reset_n), .start_discovery_i(start_d),
       .confirm_discovery_i(confirm_d), .striding_pc_i(pc), .eff_addr_i(eff),
       .stride_i(stride), .flush_i(flush), .pf_v_o(pf_v), .pf_addr_o(pf_addr),
       .pf_ready_i(pf_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: every accepted prefetch must be the next expected address
    always @(negedge clk) begin
        logic [VA-1:0] e;
        if (reset_n && pf_v && pf_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake: got pf_addr_o %h, want no request", pf_addr);
            end else begin
                e = exp_q.pop_front();
                if (pf_addr !== e) begin
                    errors++;
                    $display("FAIL handshake addr: got %h want %h", pf_addr, e);
                end
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [VA-1:0] act, logic [VA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic rst();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic confirm(logic [VA-1:0] p, logic [VA-1:0] e, logic [7:0] s);
        pc = p; eff = e; stride = s; confirm_d = 1'b1;
        cyc();
        confirm_d = 1'b0;
    endtask

    task automatic quiet(int n, string name);
        for (int i = 0; i < n; i++) begin
            chk_bit(name, pf_v, 1'b0);
            cyc();
        end
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d prefetches outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; start_d = 1'b0; confirm_d = 1'b0; flush = 1'b0; pf_ready = 1'b0;
        pc = '0; eff = '0; stride = '0;
        cyc(2);
        chk_bit("reset pf_v_o", pf_v, 1'b0);
        chk("reset pf_addr_o", pf_addr, '0);
        reset_n = 1'b1;
        cyc();

        // basic stream with two-cycle latency
        pf_ready = 1'b1;
        exp_q.push_back(39'h1008); exp_q.push_back(39'h1010);
        confirm(39'h80000100, 39'h1000, 8'h08);
        chk_bit("latency t+1", pf_v, 1'b0);
        cyc();
        chk_bit("latency t+2 valid", pf_v, 1'b1);
        chk("latency t+2 addr", pf_addr, 39'h1008);
        cyc();
        chk("t+3 addr", pf_addr, 39'h1010);
        cyc();
        chk_bit("idle after degree", pf_v, 1'b0);
        drain("basic");

        // negative stride, page rule drops first, retrain in-page
        rst(); pf_ready = 1'b1;
        confirm(39'h400, 39'h2000, 8'hF8);
        quiet(4, "neg stride page drop");
        exp_q.push_back(39'h2008); exp_q.push_back(39'h2000);
        confirm(39'h400, 39'h2010, 8'hF8);
        drain("neg stride");

        // page crossing: none at all, then one before the boundary
        rst(); pf_ready = 1'b1;
        confirm(39'h500, 39'h1FF8, 8'h08);
        quiet(4, "cross page none");
        exp_q.push_back(39'h1FF8);
        confirm(39'h600, 39'h1FF0, 8'h08);
        drain("cross page one");
        quiet(3, "cross page stop");

        // zero stride ignored
        confirm(39'h700, 39'h3000, 8'h00);
        quiet(4, "zero stride");

        // stall holds the request
        rst(); pf_ready = 1'b0;
        exp_q.push_back(39'h3010); exp_q.push_back(39'h3020);
        confirm(39'h800, 39'h3000, 8'h10);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk_bit("stall valid", pf_v, 1'b1);
            chk("stall addr", pf_addr, 39'h3010);
            if (i < 2) cyc();
        end
        pf_ready = 1'b1;
        cyc(2);
        chk("after stall addr", pf_addr, 39'h3020);
        drain("stall");

        // six streams into four entries: the fifth evicts entry 0, sixth entry 1
        rst(); pf_ready = 1'b0;
        exp_q.push_back(39'h10008);
        exp_q.push_back(39'h60008); exp_q.push_back(39'h30008);
        exp_q.push_back(39'h40008); exp_q.push_back(39'h50008);
        exp_q.push_back(39'h60010); exp_q.push_back(39'h30010);
        exp_q.push_back(39'h40010); exp_q.push_back(39'h50010);
        for (int i = 1; i <= 6; i++)
            confirm(VA'(i * 'h100), VA'(i * 'h10000), 8'h08);
        cyc(3);
        chk("victim stalled addr", pf_addr, 39'h10008);
        pf_ready = 1'b1;
        drain("victim");

        // start_discovery invalidates the stream behind the in-flight request
        rst(); pf_ready = 1'b0;
        exp_q.push_back(39'h5008);
        confirm(39'h700, 39'h5000, 8'h08);
        cyc();
        chk_bit("start stalled valid", pf_v, 1'b1);
        pc = 39'h700; stride = 8'h08; start_d = 1'b1;
        cyc();
        start_d = 1'b0; pf_ready = 1'b1;
        drain("start invalidate");
        quiet(3, "start no more");

        // confirm beats start in the same cycle
        rst(); pf_ready = 1'b1;
        exp_q.push_back(39'hA008); exp_q.push_back(39'hA010);
        pc = 39'hA00; eff = 39'hA000; stride = 8'h08; confirm_d = 1'b1; start_d = 1'b1;
        cyc();
        confirm_d = 1'b0; start_d = 1'b0;
        drain("confirm priority");

        // asynchronous reset mid-stall
        rst(); pf_ready = 1'b0;
        confirm(39'h900, 39'h6000, 8'h08);
        cyc();
        chk_bit("pre-reset valid", pf_v, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk_bit("async reset valid", pf_v, 1'b0);
        chk("async reset addr", pf_addr, '0);
        cyc();
        reset_n = 1'b1; pf_ready = 1'b1;
        quiet(4, "post reset quiet");

        // flush mid-stall
        pf_ready = 1'b0;
        confirm(39'hB00, 39'h7000, 8'h08);
        cyc();
        chk_bit("pre-flush valid", pf_v, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_bit("flush valid", pf_v, 1'b0);
        pf_ready = 1'b1;
        quiet(3, "post flush quiet");

        drain("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
